gecko_multicycle_shifter: RTL and testbench

Parametrised, iterative shift/rotate unit for the gecko execute path. It replaces the single-cycle barrel shift with a stride-decomposed, multi-cycle engine that trades latency for area. It adds rotate modes and a configurable data width and per-cycle step size. Operands arrive on a valid/ready input stream; results leave on a valid/ready output stream.

---
 rtl/gecko_multicycle_shifter.sv | 156 +++++++++++++++
 tb/tb_gecko_multicycle_shifter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gecko_multicycle_shifter.sv
// Iterative shift/rotate unit: strided amount, up to 2^MAX_STEP_LOG2 bits moved per cycle.
// Latency: max(k,1) cycles from accept to out_valid, where k is the step count.
// Backpressure: result holds while out_valid && !out_ready; in_ready is low until it is consumed.
// Ports: clk/rst_n; in_valid/in_ready/in_value/in_shift/in_stride/in_shift_type/in_rotate command stream;
//        out_valid/out_ready/out_value result stream; busy = engine not idle.
module gecko_multicycle_shifter #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_STEP_LOG2 = 2,
    parameter int ENABLE_ROTATE = 1,
    localparam int SHIFT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_value,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    input  logic [2:0]             in_stride,
    input  logic [1:0]             in_shift_type,
    input  logic                   in_rotate,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_value,
    output logic                   busy
);

    localparam logic [SHIFT_WIDTH-1:0] MAX_STEP = SHIFT_WIDTH'(1) << MAX_STEP_LOG2;
    localparam logic [DATA_WIDTH-1:0]  ALL_ONES = {DATA_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  work;
    logic [SHIFT_WIDTH-1:0] remaining;
    logic                   rot_q, right_q, arith_q, sign_q;

    logic                   accept;
    logic [2:0]             stride_eff;
    logic [SHIFT_WIDTH-1:0] amt;
    logic                   cap_rot, cap_right, cap_arith;

    logic [DATA_WIDTH-1:0]  src_val;
    logic [SHIFT_WIDTH-1:0] src_rem;
    logic                   src_rot, src_right, src_arith, src_sign;
    logic [SHIFT_WIDTH-1:0] step;
    logic [SHIFT_WIDTH-1:0] next_rem;
    logic [DATA_WIDTH-1:0]  stepped;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_value = work;

    // Stride codes that would shift the whole amount out of range fall back to stride 1.
    assign stride_eff = (32'(in_stride) >= SHIFT_WIDTH) ? 3'd0 : in_stride;
    assign amt        = in_shift << stride_eff;

    assign cap_rot   = (ENABLE_ROTATE != 0) && in_rotate;
    assign cap_right = (in_shift_type == 2'd1) || (in_shift_type == 2'd2);
    assign cap_arith = (in_shift_type == 2'd2) && !cap_rot;

    // The first step is taken in the accept cycle itself, so a k-step operation
    // presents its result k cycles after accept (1 cycle when no shift is needed).
    assign src_val   = accept ? in_value : work;
    assign src_rem   = accept ? amt : remaining;
    assign src_rot   = accept ? cap_rot : rot_q;
    assign src_right = accept ? cap_right : right_q;
    assign src_arith = accept ? cap_arith : arith_q;
    assign src_sign  = accept ? in_value[DATA_WIDTH-1] : sign_q;

    // Largest power of two not exceeding min(remaining, MAX_STEP); zero when nothing is left.
    always_comb begin
        step = '0;
        if (src_rem >= MAX_STEP) begin
            step = MAX_STEP;
        end else begin
            for (int i = 0; i < SHIFT_WIDTH; i++) begin
                if (src_rem[i]) step = SHIFT_WIDTH'(1) << i;
            end
        end
    end

    assign next_rem = src_rem - step;

    // Only MAX_STEP_LOG2+1 fixed-distance shifters are muxed, instead of a full barrel shifter.
    always_comb begin
        stepped = src_val;
        for (int j = 0; j <= MAX_STEP_LOG2; j++) begin
            if (step == (SHIFT_WIDTH'(1) << j)) begin
                if (src_rot) begin
                    if (src_right)
                        stepped = (src_val >> (1 << j)) | (src_val << (DATA_WIDTH - (1 << j)));
                    else
                        stepped = (src_val << (1 << j)) | (src_val >> (DATA_WIDTH - (1 << j)));
                end else if (src_right) begin
                    stepped = (src_val >> (1 << j))
                            | ((src_arith && src_sign) ? ~(ALL_ONES >> (1 << j)) : '0);
                end else begin
                    stepped = src_val << (1 << j);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            remaining <= '0;
            rot_q     <= 1'b0;
            right_q   <= 1'b0;
            arith_q   <= 1'b0;
            sign_q    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            work      <= stepped;
            remaining <= next_rem;
            rot_q     <= cap_rot;
            right_q   <= cap_right;
            arith_q   <= cap_arith;
            sign_q    <= in_value[DATA_WIDTH-1];
            busy      <= 1'b1;
            if (next_rem == '0) begin
                state     <= DONE;
                out_valid <= 1'b1;
            end else begin
                state     <= SHIFT;
                out_valid <= 1'b0;
            end
        end else begin
            case (state)
                SHIFT: begin
                    work      <= stepped;
                    remaining <= next_rem;
                    if (next_rem == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gecko_multicycle_shifter.sv
module tb_gecko_multicycle_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready_nr;
    logic [31:0] in_value;
    logic [4:0]  in_shift;
    logic [2:0]  in_stride;
    logic [1:0]  in_shift_type;
    logic        in_rotate;
    logic        out_valid, out_valid_nr;
    logic        out_ready;
    logic [31:0] out_value, out_value_nr;
    logic        busy, busy_nr;

    int checks = 0;
    int errors = 0;

    gecko_multicycle_shifter #(.DATA_WIDTH(32), .MAX_STEP_LOG2(2), .ENABLE_ROTATE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .in_shift(in_shift), .in_stride(in_stride), .in_shift_type(in_shift_type),
        .in_rotate(in_rotate),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .busy(busy)
    );

    // Same stimulus with rotation disabled; runs in lockstep since step counts match.
    gecko_multicycle_shifter #(.DATA_WIDTH(32), .MAX_STEP_LOG2(2), .ENABLE_ROTATE(0)) dut_nr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_nr), .in_value(in_value),
        .in_shift(in_shift), .in_stride(in_stride), .in_shift_type(in_shift_type),
        .in_rotate(in_rotate),
        .out_valid(out_valid_nr), .out_ready(out_ready), .out_value(out_value_nr), .busy(busy_nr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single-shot reference shift/rotate of v by the effective amount.
    function automatic logic [31:0] ref_res(input logic [31:0] v, input logic [4:0] sh,
                                            input logic [2:0] st, input logic [1:0] ty,
                                            input logic rot);
        logic [31:0] w;
        logic [4:0]  a;
        w = 32'(sh) << ((st >= 3'd5) ? 3'd0 : st);
        a = w[4:0];
        if (rot) begin
            if (ty == 2'd1 || ty == 2'd2) return (v >> a) | (v << (6'd32 - 6'(a)));
            return (v << a) | (v >> (6'd32 - 6'(a)));
        end
        case (ty)
            2'd1:    return v >> a;
            2'd2:    return 32'($signed(v) >>> a);
            default: return v << a;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] sh, input logic [2:0] st);
        logic [31:0] w;
        int a, k;
        w = 32'(sh) << ((st >= 3'd5) ? 3'd0 : st);
        a = int'(w[4:0]);
        k = a / 4 + (a % 2) + ((a / 2) % 2);
        return (k == 0) ? 1 : k;
    endfunction

    task automatic send(input string tag, input logic [31:0] v, input logic [4:0] sh,
                        input logic [2:0] st, input logic [1:0] ty, input logic rot,
                        input logic [31:0] exp, input logic [31:0] exp_nr, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        in_value = v; in_shift = sh; in_stride = st; in_shift_type = ty; in_rotate = rot;
        in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_value = $urandom; in_shift = 5'($urandom); in_rotate = 1'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_val"}, out_value, exp);
        chk({tag, "_nr"}, out_value_nr, exp_nr);
    endtask

    initial begin
        int spurious;
        logic [31:0] v;
        logic [4:0]  sh;
        logic [2:0]  st;
        logic [1:0]  ty;
        logic        rot;

        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_shift = '0; in_stride = '0;
        in_shift_type = '0; in_rotate = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_ovld", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_oval", out_value, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst_irdy", in_ready, 1'b1);

        send("ll13",     32'h0000_0001, 5'd13, 3'd0, 2'd0, 1'b0, 32'h0000_2000, 32'h0000_2000, 4);
        send("ra31",     32'h8000_0000, 5'd31, 3'd0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9);
        send("rl31",     32'h8000_0000, 5'd31, 3'd0, 2'd1, 1'b0, 32'h0000_0001, 32'h0000_0001, 9);
        send("rl_st3",   32'hF000_0000, 5'd3,  3'd3, 2'd1, 1'b0, 32'h0000_00F0, 32'h0000_00F0, 6);
        send("rl_st7",   32'hF000_0000, 5'd3,  3'd7, 2'd1, 1'b0, 32'h1E00_0000, 32'h1E00_0000, 2);
        send("rl_st5",   32'hF000_0000, 5'd3,  3'd5, 2'd1, 1'b0, 32'h1E00_0000, 32'h1E00_0000, 2);
        send("ll_st4",   32'h0000_0001, 5'd3,  3'd4, 2'd0, 1'b0, 32'h0001_0000, 32'h0001_0000, 4);
        send("rotl4",    32'h8000_0001, 5'd4,  3'd0, 2'd0, 1'b1, 32'h0000_0018, 32'h0000_0010, 1);
        send("rotr4",    32'h0000_0018, 5'd4,  3'd0, 2'd1, 1'b1, 32'h8000_0001, 32'h0000_0001, 1);
        send("rotr_ra8", 32'h0000_000F, 5'd8,  3'd0, 2'd2, 1'b1, 32'h0F00_0000, 32'h0000_0000, 2);
        send("t3_ll8",   32'h0000_00FF, 5'd8,  3'd0, 2'd3, 1'b0, 32'h0000_FF00, 32'h0000_FF00, 2);
        send("t3_rot8",  32'hFF00_0000, 5'd8,  3'd0, 2'd3, 1'b1, 32'h0000_00FF, 32'h0000_0000, 2);
        send("ra_pos4",  32'h7000_0000, 5'd4,  3'd0, 2'd2, 1'b0, 32'h0700_0000, 32'h0700_0000, 1);
        send("zero",     32'hDEAD_BEEF, 5'd0,  3'd0, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);

        // Backpressure: hold the result, then accept a new command in the release cycle.
        @(posedge clk); #1;
        in_value = 32'h1234_5678; in_shift = 5'd0; in_stride = 3'd0; in_shift_type = 2'd0;
        in_rotate = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_value = 32'h0000_0003; in_shift = 5'd1;
        @(negedge clk);
        chk("bp_vld0", out_valid, 1'b1);
        chk("bp_val0", out_value, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_vld", out_valid, 1'b1);
            chk("bp_hold_val", out_value, 32'h1234_5678);
            chk("bp_hold_rdy", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1 chk("bp_rel_rdy", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_vld", out_valid, 1'b1);
        chk("b2b_val", out_value, 32'h0000_0006);

        // Reset in the middle of a 9-step operation.
        @(posedge clk); #1;
        in_value = 32'h8000_0000; in_shift = 5'd31; in_stride = 3'd0; in_shift_type = 2'd2;
        in_rotate = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", out_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_val", out_value, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        spurious = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        chk("mrst_spur", spurious, 0);
        send("post_rst", 32'h0000_0005, 5'd2, 3'd0, 2'd0, 1'b0, 32'h0000_0014, 32'h0000_0014, 1);

        for (int n = 0; n < 300; n++) begin
            v = $urandom; sh = 5'($urandom); st = 3'($urandom);
            ty = 2'($urandom); rot = 1'($urandom);
            send("rnd", v, sh, st, ty, rot, ref_res(v, sh, st, ty, rot),
                 ref_res(v, sh, st, ty, 1'b0), ref_lat(sh, st));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
